// File: rtl/spi_sclk_engine.sv
// SPI serial-clock / chip-select engine: runtime divider, CPOL/CPHA and bit count,
// programmable CS_N setup/hold, and sample/shift strobes aligned to SCLK edges.
module spi_sclk_engine #(
    parameter int DIV_WIDTH    = 8,
    parameter int BITS_WIDTH   = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                  system_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [BITS_WIDTH-1:0] num_bits,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  SPI_SCLK,
    output logic                  CS_N,
    output logic                  sample_stb,
    output logic                  shift_stb,
    output logic                  busy,
    output logic                  done,
    output logic [BITS_WIDTH-1:0] bit_count
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, ACTIVE, CS_HOLD, FINISH} state_t;

    localparam int PH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);

    state_t                state, state_nx;
    logic [DIV_WIDTH-1:0]  div_cnt, div_cnt_nx;
    logic [BITS_WIDTH:0]   edge_cnt, edge_cnt_nx, edge_inc;
    logic [PH_W-1:0]       ph_cnt, ph_cnt_nx;
    logic [DIV_WIDTH-1:0]  div_q, div_q_nx;
    logic [BITS_WIDTH-1:0] nbits_q, nbits_q_nx;
    logic                  cpol_q, cpol_q_nx;
    logic                  cpha_q, cpha_q_nx;
    logic                  sclk_nx, cs_n_nx, sample_nx, shift_nx, busy_nx, done_nx;
    logic [BITS_WIDTH-1:0] bit_count_nx;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            ph_cnt     <= '0;
            div_q      <= '0;
            nbits_q    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            SPI_SCLK   <= 1'b0;
            CS_N       <= 1'b1;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_count  <= '0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_cnt_nx;
            edge_cnt   <= edge_cnt_nx;
            ph_cnt     <= ph_cnt_nx;
            div_q      <= div_q_nx;
            nbits_q    <= nbits_q_nx;
            cpol_q     <= cpol_q_nx;
            cpha_q     <= cpha_q_nx;
            SPI_SCLK   <= sclk_nx;
            CS_N       <= cs_n_nx;
            sample_stb <= sample_nx;
            shift_stb  <= shift_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            bit_count  <= bit_count_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        div_cnt_nx   = div_cnt;
        edge_cnt_nx  = edge_cnt;
        ph_cnt_nx    = ph_cnt;
        div_q_nx     = div_q;
        nbits_q_nx   = nbits_q;
        cpol_q_nx    = cpol_q;
        cpha_q_nx    = cpha_q;
        sclk_nx      = SPI_SCLK;
        cs_n_nx      = CS_N;
        busy_nx      = busy;
        bit_count_nx = bit_count;
        sample_nx    = 1'b0;
        shift_nx     = 1'b0;
        done_nx      = 1'b0;
        edge_inc     = edge_cnt + (BITS_WIDTH+1)'(1);

        case (state)
            IDLE: begin
                sclk_nx = cpol_q;
                if (start && (num_bits != '0)) begin
                    div_q_nx     = clk_div;
                    nbits_q_nx   = num_bits;
                    cpol_q_nx    = cpol;
                    cpha_q_nx    = cpha;
                    sclk_nx      = cpol;
                    cs_n_nx      = 1'b0;
                    busy_nx      = 1'b1;
                    bit_count_nx = '0;
                    ph_cnt_nx    = '0;
                    state_nx     = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (ph_cnt == SETUP_LAST) begin
                    div_cnt_nx  = '0;
                    edge_cnt_nx = '0;
                    state_nx    = ACTIVE;
                end else begin
                    ph_cnt_nx = ph_cnt + PH_W'(1);
                end
            end
            ACTIVE: begin
                if (div_cnt == div_q) begin
                    div_cnt_nx  = '0;
                    sclk_nx     = ~SPI_SCLK;
                    edge_cnt_nx = edge_inc;
                    // An even count of completed edges means the coming edge is a leading one
                    if (~edge_cnt[0] ^ cpha_q) begin
                        sample_nx    = 1'b1;
                        bit_count_nx = bit_count + BITS_WIDTH'(1);
                    end else begin
                        shift_nx = 1'b1;
                    end
                    if (edge_inc == {nbits_q, 1'b0}) begin
                        ph_cnt_nx = '0;
                        state_nx  = CS_HOLD;
                    end
                end else begin
                    div_cnt_nx = div_cnt + DIV_WIDTH'(1);
                end
            end
            CS_HOLD: begin
                if (ph_cnt == HOLD_LAST) begin
                    cs_n_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = FINISH;
                end else begin
                    ph_cnt_nx = ph_cnt + PH_W'(1);
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_nx     = IDLE;
            sclk_nx      = cpol_q;
            cs_n_nx      = 1'b1;
            busy_nx      = 1'b0;
            sample_nx    = 1'b0;
            shift_nx     = 1'b0;
            done_nx      = 1'b0;
            bit_count_nx = bit_count;
        end
    end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Randomised bench for spi_sclk_engine; expected waveforms come from an edge-schedule
// model built directly from the transaction timing rules.
module tb_spi_sclk_engine;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, abort, cpol, cpha;
    logic [7:0] clk_div, num_bits;
    logic       SPI_SCLK, CS_N, sample_stb, shift_stb, busy, done;
    logic [7:0] bit_count;

    int total = 0;
    int bad   = 0;

    spi_sclk_engine dut (
        .system_clock(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .clk_div(clk_div), .num_bits(num_bits), .cpol(cpol), .cpha(cpha),
        .SPI_SCLK(SPI_SCLK), .CS_N(CS_N), .sample_stb(sample_stb), .shift_stb(shift_stb),
        .busy(busy), .done(done), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [13:0] obs();
        return {SPI_SCLK, CS_N, sample_stb, shift_stb, busy, done, bit_count};
    endfunction

    // t = cycles after the clock edge that accepted start
    function automatic logic [13:0] model(input int t, input int d, input int nb,
                                          input bit pol, input bit pha);
        int a, te, n, bc, dl;
        logic smp, shf;
        a = 1 + SETUP; n = 0; bc = 0; smp = 1'b0; shf = 1'b0;
        for (int k = 1; k <= 2 * nb; k++) begin
            te = a + (d + 1) * k;
            if (te <= t) begin
                n++;
                if (((k % 2) == 1) != pha) begin
                    bc++;
                    if (te == t) smp = 1'b1;
                end else if (te == t) begin
                    shf = 1'b1;
                end
            end
        end
        dl = a + (d + 1) * 2 * nb + HOLD;
        return {pol ^ n[0], (t >= dl), smp, shf, (t < dl), (t == dl), 8'(bc)};
    endfunction

    function automatic int done_at(input int d, input int nb);
        return 1 + SETUP + (d + 1) * 2 * nb + HOLD;
    endfunction

    task automatic kick(input int d, input int nb, input bit pol, input bit pha);
        @(negedge clk);
        clk_div = 8'(d); num_bits = 8'(nb); cpol = pol; cpha = pha; start = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        clk_div = 8'd0; num_bits = 8'd0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        e = 14'b01_0000_00000000;
        total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_state got=%h exp=%h", obs(), e); end
        reset_n = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (obs() !== e) begin bad++; $display("FAIL idle_abort got=%h exp=%h", obs(), e); end
        kick(2, 0, 1'b1, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL zero_bits t=%0d got=%h exp=%h", t, obs(), e); end
        end
    endtask

    task automatic test_basic();
        logic [13:0] e;
        int spl = 0, dn_t = -1, cs_fall = -1;
        kick(2, 8, 1'b0, 1'b0);
        for (int t = 1; t <= done_at(2, 8) + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, 2, 8, 1'b0, 1'b0);
            if (sample_stb && SPI_SCLK) spl++;
            if (done && dn_t < 0) dn_t = t;
            if (!CS_N && cs_fall < 0) cs_fall = t;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL basic t=%0d got=%h exp=%h", t, obs(), e); end
        end
        total++;
        if (spl !== 8) begin bad++; $display("FAIL basic_rising_samples got=%0d exp=8", spl); end
        total++;
        if (dn_t !== 53) begin bad++; $display("FAIL basic_done_time got=%0d exp=53", dn_t); end
        total++;
        if (cs_fall !== 1) begin bad++; $display("FAIL basic_cs_fall got=%0d exp=1", cs_fall); end
    endtask

    task automatic test_mode11();
        logic [13:0] e;
        int spl = 0;
        kick(0, 3, 1'b1, 1'b1);
        for (int t = 1; t <= done_at(0, 3) + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, 0, 3, 1'b1, 1'b1);
            if (sample_stb && SPI_SCLK) spl++;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL mode11 t=%0d got=%h exp=%h", t, obs(), e); end
        end
        total++;
        if (spl !== 3) begin bad++; $display("FAIL mode11_rising_samples got=%0d exp=3", spl); end
    endtask

    task automatic test_random();
        logic [13:0] e;
        int d, nb;
        bit pol, pha;
        repeat (6) begin
            d = $urandom_range(0, 4); nb = $urandom_range(1, 12);
            pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
            kick(d, nb, pol, pha);
            for (int t = 1; t <= done_at(d, nb) + 2; t++) begin
                @(negedge clk);
                start = 1'b0;
                e = model(t, d, nb, pol, pha);
                total++;
                if (obs() !== e) begin
                    bad++;
                    $display("FAIL random d=%0d nb=%0d pol=%0d pha=%0d t=%0d got=%h exp=%h",
                             d, nb, pol, pha, t, obs(), e);
                end
            end
        end
    endtask

    task automatic test_ignore();
        logic [13:0] e;
        int d, nb, dl;
        bit pol, pha;
        d = $urandom_range(1, 3); nb = $urandom_range(4, 9);
        pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
        dl = done_at(d, nb);
        kick(d, nb, pol, pha);
        for (int t = 1; t <= dl + 4; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d, nb, pol, pha);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL ignore t=%0d got=%h exp=%h", t, obs(), e); end
            if (t == 1) begin
                clk_div = 8'($urandom_range(5, 9)); num_bits = 8'($urandom_range(1, 3));
                cpol = ~pol; cpha = ~pha;
            end
            if (t == SETUP + 3 || t == dl) start = 1'b1;
        end
    endtask

    task automatic test_abort();
        logic [13:0] e, eab;
        int d, ta, d2, nb2;
        bit pol, pha;
        d = $urandom_range(0, 3);
        pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
        ta = 1 + SETUP + (d + 1) * 7;
        eab = model(ta, d, 24, pol, pha);
        eab = {pol, 1'b1, 4'b0000, eab[7:0]};
        kick(d, 24, pol, pha);
        for (int t = 1; t <= ta + 6; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (t == ta);
            e = (t > ta) ? eab : model(t, d, 24, pol, pha);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL abort t=%0d got=%h exp=%h", t, obs(), e); end
        end
        d2 = $urandom_range(0, 2); nb2 = $urandom_range(1, 6);
        kick(d2, nb2, ~pol, pha);
        for (int t = 1; t <= done_at(d2, nb2) + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d2, nb2, ~pol, pha);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL after_abort t=%0d got=%h exp=%h", t, obs(), e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        int d, nb, t5, d2, nb2;
        bit pol, pha;
        d = $urandom_range(0, 3); nb = $urandom_range(3, 10);
        pol = 1'b1; pha = 1'($urandom_range(0, 1));
        t5 = 1 + SETUP + (d + 1) * 5;
        kick(d, nb, pol, pha);
        for (int t = 1; t <= t5; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d, nb, pol, pha);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL pre_reset t=%0d got=%h exp=%h", t, obs(), e); end
        end
        #1 reset_n = 1'b0;
        #1;
        e = 14'b01_0000_00000000;
        total++;
        if (obs() !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs(), e); end
        @(negedge clk);
        reset_n = 1'b1;
        d2 = $urandom_range(0, 3); nb2 = $urandom_range(1, 8);
        kick(d2, nb2, 1'b0, 1'b1);
        for (int t = 1; t <= done_at(d2, nb2) + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d2, nb2, 1'b0, 1'b1);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL after_reset t=%0d got=%h exp=%h", t, obs(), e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        int d1, nb1, d2, nb2, gap = 0;
        bit pol, pha;
        d1 = $urandom_range(0, 2); nb1 = $urandom_range(1, 6);
        d2 = $urandom_range(0, 2); nb2 = $urandom_range(1, 6);
        pol = 1'($urandom_range(0, 1)); pha = 1'($urandom_range(0, 1));
        kick(d1, nb1, pol, pha);
        for (int t = 1; t <= done_at(d1, nb1) + 1; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d1, nb1, pol, pha);
            if (CS_N) gap++;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL b2b_first t=%0d got=%h exp=%h", t, obs(), e); end
        end
        clk_div = 8'(d2); num_bits = 8'(nb2); cpol = ~pol; cpha = ~pha; start = 1'b1;
        for (int t = 1; t <= done_at(d2, nb2) + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            e = model(t, d2, nb2, ~pol, ~pha);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL b2b_second t=%0d got=%h exp=%h", t, obs(), e); end
        end
        total++;
        if (gap !== 2) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=2", gap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode11();
        test_random();
        test_ignore();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
